// File: rtl/rv64_pkg.sv
// rv64_pkg: shared constants and types for the RV64 fetch stage
// Holds XLEN, RESET_PC, INSTR_NOP, the fetch state encoding and the buffered entry type.
package rv64_pkg;
    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic {RUN, HALT} fetch_state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: DEPTH-entry synchronous FIFO of fetch entries with flush
// Ports: clk; rst (async, active-low); flush (empties the FIFO, a same-cycle push becomes the only entry);
//        push/push_data; pop (ignored when empty or flushing); head (entry at read pointer);
//        count/full/empty (occupancy status).
module fetch_buf
    import rv64_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;

    assign do_pop = pop && !empty && !flush;
    assign head   = mem[rd_ptr];
    assign empty  = count == '0;
    assign full   = count == (AW+1)'(DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(push);
            count  <= (AW+1)'(push);
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: the top masks the head while the FIFO is empty.
    always_ff @(posedge clk)
        if (push) mem[flush ? '0 : wr_ptr] <= push_data;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: RV64 fetch stage owning the fetch PC, issuing imem reads and buffering words for decode
// Ports: clk; rst (async, active-low);
//        imem_req_valid/ready/addr (read request); imem_resp_valid/data/err (in-order response, no backpressure);
//        redirect_valid/redirect_pc (one-cycle branch/jump redirect from execute);
//        instr_valid/instr_ready/instr_out/pc_out/fetch_fault (buffer head towards decode).
module inst_fetch_unit #(
    parameter int              XLEN      = rv64_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = rv64_pkg::RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            imem_resp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            fetch_fault
);
    import rv64_pkg::*;

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   out_next;
    logic [CW-1:0]   count;
    logic            misaligned;
    logic            req_fire;
    logic            resp_live;
    logic            push;
    logic            full;
    logic            empty;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    assign misaligned = redirect_pc[1:0] != 2'b00;

    // Credit rule: every request in flight owns a free buffer slot, so responses never need backpressure.
    // Gating with rst keeps the request low while reset is held.
    assign imem_req_valid = rst && state == RUN && !redirect_valid &&
                            ({1'b0, outstanding} + {1'b0, count} < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_live      = imem_resp_valid && drop_cnt == '0;
    assign out_next       = outstanding + CW'(req_fire) - CW'(imem_resp_valid);
    assign push           = redirect_valid ? misaligned : resp_live;

    always_comb begin
        push_data.instr = (redirect_valid || imem_resp_err) ? '0 : imem_resp_data;
        push_data.pc    = redirect_valid ? redirect_pc : resp_pc;
        push_data.fault = redirect_valid || imem_resp_err;
    end

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (instr_valid && instr_ready),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign instr_valid = !empty;
    assign instr_out   = empty ? '0 : head.instr;
    assign pc_out      = empty ? RESET_PC : head.pc;
    assign fetch_fault = !empty && head.fault;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect_valid) begin
                state    <= misaligned ? HALT : RUN;
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                // A response arriving now is discarded by the flush itself, so it is not counted again.
                drop_cnt <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (resp_live) resp_pc <= resp_pc + XLEN'(4);
                if (resp_live && imem_resp_err) begin
                    state    <= HALT;
                    drop_cnt <= out_next;
                end else if (imem_resp_valid && !resp_live) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    a_resp_has_req: assert property (@(posedge clk) disable iff (!rst)
        imem_resp_valid |-> outstanding != '0);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && full && !instr_ready && !redirect_valid));
endmodule
